// File: rtl/hdmi_pattern_gen.sv
// 640x480@60 colour-bar source driven out as DVI/HDMI TMDS from a single 125 MHz clock.
// Pixel rate is CLK/5; each 10-bit word leaves two bits per CLK, even bit in the high phase.
module hdmi_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 5
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       HDMI_CLK_P,
    output logic       HDMI_CLK_N,
    output logic [2:0] HDMI_P,
    output logic [2:0] HDMI_N
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] CLK_WORD = 10'b1111100000;

    logic [2:0]             div;
    logic                   pe;
    logic [9:0]             hcnt;
    logic [9:0]             vcnt;
    logic                   active;
    logic                   hsync_on;
    logic                   vsync_on;

    logic                   vld_p0;
    logic                   de_p0;
    logic                   hsync_p0;
    logic                   vsync_p0;
    logic signed [23:0]     rgb_p0;

    logic signed [5:0]      disp [3];
    logic [15:0]            enc [3];
    logic [3:0][9:0]        word;
    logic [3:0]             even_bit;
    logic [3:0]             odd_bit;
    logic [3:0][7:0]        rest;

    function automatic logic [23:0] bar_color(input logic [9:0] h);
        logic [9:0] idx;
        idx = h / 10'd80;
        case (idx)
            10'd0:   bar_color = 24'hFFFFFF;
            10'd1:   bar_color = 24'hFFFF00;
            10'd2:   bar_color = 24'h00FFFF;
            10'd3:   bar_color = 24'h00FF00;
            10'd4:   bar_color = 24'hFF00FF;
            10'd5:   bar_color = 24'hFF0000;
            10'd6:   bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    endfunction

    function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
        case ({c1, c0})
            2'b00:   ctrl_token = 10'b1101010100;
            2'b01:   ctrl_token = 10'b0010101011;
            2'b10:   ctrl_token = 10'b0101010100;
            default: ctrl_token = 10'b1010101011;
        endcase
    endfunction

    // Returns {next running disparity, 10-bit symbol}.
    function automatic logic [15:0] tmds_encode(input logic [7:0] d, input logic signed [5:0] cnt);
        logic [8:0]        qm;
        logic [3:0]        n1d;
        logic [3:0]        n1q;
        logic signed [5:0] n1;
        logic signed [5:0] n0;
        logic signed [5:0] diff;
        logic signed [5:0] nxt;
        logic [9:0]        q;
        n1d = 4'($countones(d));
        qm = '0;
        qm[0] = d[0];
        if (n1d > 4'd4 || (n1d == 4'd4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q  = 4'($countones(qm[7:0]));
        n1   = signed'({2'b00, n1q});
        n0   = 6'sd8 - n1;
        diff = n1 - n0;
        if (cnt == 6'sd0 || n1 == n0) begin
            q   = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            nxt = qm[8] ? cnt + diff : cnt - diff;
        end else if ((cnt > 6'sd0 && n1 > n0) || (cnt < 6'sd0 && n0 > n1)) begin
            q   = {1'b1, qm[8], ~qm[7:0]};
            nxt = cnt + (qm[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            q   = {1'b0, qm[8], qm[7:0]};
            nxt = cnt - (qm[8] ? 6'sd0 : 6'sd2) + diff;
        end
        tmds_encode = {nxt, q};
    endfunction

    assign pe       = (div == 3'(CLK_DIV - 1));
    assign active   = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
    assign hsync_on = (hcnt >= 10'(H_ACTIVE + H_FP)) && (hcnt < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_on = (vcnt >= 10'(V_ACTIVE + V_FP)) && (vcnt < 10'(V_ACTIVE + V_FP + V_SYNC));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            div <= pe ? 3'd0 : div + 3'd1;
            if (pe) begin
                if (hcnt == 10'(H_TOTAL - 1)) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    // ---- stage p0: pattern and sync registers ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_p0   <= 1'b0;
            de_p0    <= 1'b0;
            hsync_p0 <= 1'b1;
            vsync_p0 <= 1'b1;
        end else if (pe) begin
            vld_p0   <= 1'b1;
            de_p0    <= active;
            hsync_p0 <= ~hsync_on;
            vsync_p0 <= ~vsync_on;
        end
    end

    always_ff @(posedge CLK) begin
        if (pe) rgb_p0 <= active ? bar_color(hcnt) : 24'h000000;
    end

    // ---- stage p1: TMDS encode into the serializer load ----
    always_comb begin
        for (int c = 0; c < 3; c++) enc[c] = tmds_encode(rgb_p0[8*c +: 8], disp[c]);
        word[0] = de_p0 ? enc[0][9:0] : ctrl_token(vsync_p0, hsync_p0);
        word[1] = de_p0 ? enc[1][9:0] : ctrl_token(1'b0, 1'b0);
        word[2] = de_p0 ? enc[2][9:0] : ctrl_token(1'b0, 1'b0);
        word[3] = CLK_WORD;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int c = 0; c < 3; c++) disp[c] <= '0;
        end else if (pe && vld_p0) begin
            for (int c = 0; c < 3; c++) disp[c] <= de_p0 ? signed'(enc[c][15:10]) : 6'sd0;
        end
    end

    // Lane 3 carries the TMDS clock so it stays bit-aligned with the data lanes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            even_bit <= '0;
            odd_bit  <= '0;
            rest     <= '0;
        end else if (pe && vld_p0) begin
            for (int l = 0; l < 4; l++) begin
                even_bit[l] <= word[l][0];
                odd_bit[l]  <= word[l][1];
                rest[l]     <= word[l][9:2];
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                even_bit[l] <= rest[l][0];
                odd_bit[l]  <= rest[l][1];
                rest[l]     <= {2'b00, rest[l][7:2]};
            end
        end
    end

    assign HDMI_P     = CLK ? even_bit[2:0] : odd_bit[2:0];
    assign HDMI_N     = ~HDMI_P;
    assign HDMI_CLK_P = CLK ? even_bit[3] : odd_bit[3];
    assign HDMI_CLK_N = ~HDMI_CLK_P;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: deserializes all lanes and checks decoded pixels, control tokens,
// disparity bounds and reset behaviour; vertical timing is shortened to fit whole frames in the run.
module tb_hdmi_pattern_gen;

    localparam int HA  = 640;
    localparam int HFP = 16;
    localparam int HS  = 96;
    localparam int HBP = 48;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int VT  = VA + VFP + VS + VBP;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       HDMI_CLK_P;
    logic       HDMI_CLK_N;
    logic [2:0] HDMI_P;
    logic [2:0] HDMI_N;

    int tests = 0;
    int fails = 0;
    int sum [3];

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    hdmi_pattern_gen #(
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .HDMI_CLK_P(HDMI_CLK_P),
        .HDMI_CLK_N(HDMI_CLK_N),
        .HDMI_P(HDMI_P),
        .HDMI_N(HDMI_N)
    );

    always #4 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check(tag, {HDMI_CLK_N, HDMI_CLK_P, HDMI_N, HDMI_P}, 8'b1_0_111_000);
    endtask

    function automatic logic [9:0] token(input logic c1, input logic c0);
        case ({c1, c0})
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    task automatic check_word(input int n, input logic [3:0][9:0] w, input int nbad);
        int h;
        int v;
        logic hs;
        logic vs;
        logic [23:0] rgb;
        logic [7:0] q;
        logic [7:0] d;
        h = n % HT;
        v = (n / HT) % VT;
        check("tmds_clk", w[3], 10'b1111100000);
        check("n_legs", nbad, 0);
        if (h < HA && v < VA) begin
            rgb = bars[h / 80];
            for (int c = 0; c < 3; c++) begin
                q = w[c][9] ? ~w[c][7:0] : w[c][7:0];
                d[0] = q[0];
                for (int i = 1; i < 8; i++) d[i] = w[c][8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
                check($sformatf("pix ch%0d h%0d v%0d", c, h, v), d, rgb[8*c +: 8]);
                check($sformatf("tmin ch%0d h%0d", c, h), (q == 8'h00 || q == 8'hFF), 1);
                if (h == 0) begin
                    sum[c] = 0;
                    check($sformatf("disp_rst ch%0d v%0d", c, v), w[c], 10'b1000000000);
                end
                sum[c] += 2 * $countones(w[c]) - 10;
                if (h == HA - 1)
                    check($sformatf("disp_end ch%0d v%0d sum%0d", c, v, sum[c]),
                          (sum[c] <= 10 && sum[c] >= -10), 1);
            end
        end else begin
            hs = (h >= HA + HFP) && (h < HA + HFP + HS);
            vs = (v >= VA + VFP) && (v < VA + VFP + VS);
            check($sformatf("tok ch0 h%0d v%0d", h, v), w[0], token(!vs, !hs));
            check($sformatf("tok ch1 h%0d v%0d", h, v), w[1], token(1'b0, 1'b0));
            check($sformatf("tok ch2 h%0d v%0d", h, v), w[2], token(1'b0, 1'b0));
        end
    endtask

    task automatic grab(inout logic [3:0][9:0] w, input int b, inout int nbad);
        for (int c = 0; c < 3; c++) w[c][b] = HDMI_P[c];
        w[3][b] = HDMI_CLK_P;
        if (HDMI_N !== ~HDMI_P || HDMI_CLK_N !== ~HDMI_CLK_P) nbad++;
    endtask

    // Releases reset between edges, then follows pixel words from pixel 0.
    task automatic run_after_release(input int npix);
        logic [3:0][9:0] w;
        int nbad;
        @(negedge CLK);
        #1 RST = 1'b1;
        for (int e = 1; e < 10; e++) begin
            @(posedge CLK);
            #1 check_reset("pre_load_hi");
            @(negedge CLK);
            #1 check_reset("pre_load_lo");
        end
        for (int n = 0; n < npix; n++) begin
            w = '0;
            nbad = 0;
            for (int k = 0; k < 5; k++) begin
                @(posedge CLK);
                #1 grab(w, 2 * k, nbad);
                @(negedge CLK);
                #1 grab(w, 2 * k + 1, nbad);
            end
            check_word(n, w, nbad);
        end
    endtask

    task automatic async_reset(input int hold_clks);
        repeat ($urandom_range(0, 4)) @(posedge CLK);
        @(posedge CLK);
        #($urandom_range(1, 2)) RST = 1'b0;
        #1 check_reset("async_rst");
        repeat (hold_clks) begin
            @(posedge CLK);
            #1 check_reset("in_rst");
        end
    endtask

    initial begin
        RST = 1'b0;
        for (int i = 0; i < 600 + int'($urandom_range(0, 20)); i++) begin
            @(posedge CLK);
            if (i % 100 == 50) #1 check_reset("por");
        end
        run_after_release(VT * HT + HT);
        async_reset(3);
        run_after_release(3 * HT + int'($urandom_range(0, 400)));
        async_reset(3);
        run_after_release(2 * HT + int'($urandom_range(0, 400)));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

endmodule
